eigen_freq_gen: RTL and testbench
=================================

# eigen_freq_gen

Parametrised multi-channel eigen-frequency pattern generator for the FOCT modulation front end. It is clocked from the reference clock and produces NCH independent periodic on/off patterns. Each channel has its own programmable period, high time and phase. Channel 0 and channel 1 reset to the legacy temperature pattern (1 high, 2 low) and current pattern (2 high, 1 low). Configuration is double-buffered, so new settings take effect only at a period boundary and never cut a pattern short.

## Interface
Parameters:
- NCH, 2, number of channels (1..8)
- CNT_W, 8, counter and config field width
- DEF_PERIOD, 3, reset period for all channels
- DEF_HIGH0, 1, reset high time of channel 0 (temperature)
- DEF_HIGH1, 2, reset high time of channels ≥1 (current)

Ports:
- Refin_Clk  in  1  reference clock, all logic on its rising edge
- SYS_START  in  1  asynchronous, active-low reset; low clears everything, release starts nothing until Run=1
- Run  in  1  pattern enable, level sensitive
- Sync  in  1  one-cycle realign pulse for all channels
- Cfg_We  in  1  config write strobe
- Cfg_Ch  in  $clog2(NCH) (min 1)  target channel
- Cfg_Period  in  CNT_W  period in cycles
- Cfg_High  in  CNT_W  cycles high per period, starting at count 0
- Cfg_Phase  in  CNT_W  count value produced on the first edge after Sync or start
- Cfg_Err  out  1  one-cycle pulse when a write is rejected
- Eigen_Out  out  NCH  pattern outputs, registered
- Frame_Strobe  out  NCH  one-cycle pulse, registered, high while the channel's count is 0

## Operation
- Per channel, active registers are P, H and F (period, high time, phase). The shadow registers are P', H' and F'. The count register is C.
- Reset values:
  - P = P' = DEF_PERIOD.
  - H = H' = DEF_HIGH0 for channel 0 and DEF_HIGH1 for the others.
  - F = F' = 0.
  - C = P−1.
  - Eigen_Out = 0, Frame_Strobe = 0, Cfg_Err = 0.
- Write rules:
  - A write with Cfg_Ch ≥ NCH, Cfg_Period < 2, or Cfg_Phase ≥ Cfg_Period is rejected. Rejection means no register changes and Cfg_Err=1 on the next cycle.
  - Otherwise the write loads P', H' and F' of the target channel.
- Cfg_High = 0 gives a constant-low output. Cfg_High ≥ Cfg_Period gives a constant-high output. Both are legal.
- Each edge with Run=1 and Sync=0:
  - nC = (C==P−1) ? 0 : C+1.
  - C ← nC.
  - Eigen_Out ← (nC < H).
  - Frame_Strobe ← (nC == 0).
- Shadow transfer: when nC == 0, P, H and F are first loaded from the shadows, and nC and the output are evaluated with the new P and H.
- Run=0 (synchronous stop):
  - P, H and F are loaded from the shadows.
  - C ← (F+P'−1) mod P', so the first running edge produces count F.
  - Eigen_Out = 0 and Frame_Strobe = 0.
- Sync=1 with Run=1: every channel does the shadow transfer, C ← F', Eigen_Out ← (F' < H'), and Frame_Strobe ← (F' == 0).
- Simultaneous events:
  - Cfg_We and a wrap on the same channel: the transfer uses the old shadow, and the new value applies at the following wrap.
  - Cfg_We with Sync: Sync uses the old shadow.
  - Sync with Run=0: Run=0 wins.
- Reset asserted mid-pattern: all outputs go to 0 asynchronously, and the config returns to its defaults.

## Timing
- Latency from Run rising to the first Eigen_Out update is 1 edge. With defaults, channel 0 reads 1,0,0,1,0,0… and channel 1 reads 1,1,0,1,1,0… starting on that first edge.
- A config write is visible at the next wrap of that channel. Worst case is P_old+1 cycles.
- Cfg_Err is asserted for exactly 1 cycle, on the edge after the write.
- Frame_Strobe coincides with the first high cycle of Eigen_Out whenever H > 0.

## Structure
- Package eigen_freq_pkg holds:
  - the CNT_W default and the legacy constants (period 3, high 1 and 2);
  - the config record typedef {period, high, phase};
  - the function is_valid_cfg(period, phase).
- Sub-module eigen_freq_chan holds one channel's shadow, active registers, counter and output flops. The top level instantiates it NCH times and handles the write decode and Cfg_Err.

## Test plan
- Defaults: release reset, Run=1 for 12 cycles. Channel 0 must be 100100100100, channel 1 must be 110110110110, and Frame_Strobe must be 100 repeated on both.
- Reconfigure mid-period: write ch0 P=5, H=2, F=0 at count 1. The old pattern completes through count 2, then 11000 repeats.
- Rejected writes: Cfg_Period=1, then Phase=4 with Period=4, then Cfg_Ch=NCH. Each must give one Cfg_Err pulse and leave the outputs unchanged.
- Sync: ch1 set to P=4, H=1, F=2, then a Sync pulse. The next edge must show count 2 (output 0, no strobe), and count 0 two edges later (output 1, strobe).
- Edge cases: H=0 keeps the output constant 0. H=9 with P=4 keeps it constant 1 while Frame_Strobe still pulses every 4 cycles.
- Reset and Run drop mid-operation: assert SYS_START low mid-pattern and all outputs must go to 0 immediately. Drop Run for 3 cycles and the outputs must read 0, then restart at count F on the first edge after Run returns high.

Source files
------------

// File: rtl/eigen_freq_gen_pkg.sv
// Package for the eigen-frequency pattern generator.
// Holds the default counter width, the legacy FOCT pattern constants
// (temperature: period 3 / high 1, current: period 3 / high 2), the
// configuration record and the write-validity check shared by the
// top-level write decode.
package eigen_freq_pkg;

  localparam int CNT_W_DEF          = 8;
  localparam int LEGACY_PERIOD      = 3;
  localparam int LEGACY_HIGH_TEMP   = 1;
  localparam int LEGACY_HIGH_CUR    = 2;

  // One channel's configuration at the default field width.
  typedef struct packed {
    logic [CNT_W_DEF-1:0] period;
    logic [CNT_W_DEF-1:0] high;
    logic [CNT_W_DEF-1:0] phase;
  } cfg_t;

  // A period below 2 cannot form an on/off pattern, and the phase must be
  // a count the counter can actually reach. Callers zero-extend to 32 bits
  // so the check works for any CNT_W.
  function automatic logic is_valid_cfg(input logic [31:0] period,
                                        input logic [31:0] phase);
    return (period >= 32'd2) && (phase < period);
  endfunction

endpackage

// File: rtl/eigen_freq_gen_if.sv
// Configuration bus of the eigen-frequency pattern generator.
// Ports: Cfg_We (write strobe), Cfg_Ch (target channel), Cfg_Period,
// Cfg_High, Cfg_Phase (new settings), Cfg_Err (reject pulse).
//
// Handshake: Cfg_We acts as a valid with no ready; the generator takes
// every strobed cycle. A write is either loaded into the target channel's
// shadow registers on that edge, or rejected, in which case nothing changes
// and Cfg_Err is high for exactly the following cycle.
interface eigen_freq_gen_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 8
);
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic             Cfg_We;
  logic [CH_W-1:0]  Cfg_Ch;
  logic [CNT_W-1:0] Cfg_Period;
  logic [CNT_W-1:0] Cfg_High;
  logic [CNT_W-1:0] Cfg_Phase;
  logic             Cfg_Err;

  modport master (
    output Cfg_We, Cfg_Ch, Cfg_Period, Cfg_High, Cfg_Phase,
    input  Cfg_Err
  );

  modport slave (
    input  Cfg_We, Cfg_Ch, Cfg_Period, Cfg_High, Cfg_Phase,
    output Cfg_Err
  );
endinterface

// File: rtl/eigen_freq_gen_chan.sv
// One channel of the eigen-frequency pattern generator: shadow and active
// period/high registers, the cycle counter and the registered outputs.
// Ports: clk, rst_n (async active-low), run (level enable), sync (realign
// pulse), wr/wr_period/wr_high/wr_phase (already-validated shadow load),
// eigen_out (pattern bit), frame_strobe (high while count is 0).
//
// The active phase is only ever consumed on the same edge that loads it
// from the shadow (stop and sync), so those paths read the shadow phase
// directly and no separate active-phase flop is kept.
module eigen_freq_chan #(
  parameter int CNT_W      = 8,
  parameter int DEF_PERIOD = 3,
  parameter int DEF_HIGH   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_period,
  input  logic [CNT_W-1:0] wr_high,
  input  logic [CNT_W-1:0] wr_phase,
  output logic             eigen_out,
  output logic             frame_strobe
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] p_q, h_q;          // active period / high time
  logic [CNT_W-1:0] ps_q, hs_q, fs_q;  // shadow period / high / phase
  logic [CNT_W-1:0] c_q;               // cycle count
  logic             out_q, strb_q;

  logic             wrap;
  logic [CNT_W-1:0] c_inc;
  logic [CNT_W-1:0] stop_c;

  assign wrap  = (c_q == p_q - ONE);
  assign c_inc = c_q + ONE;
  // Parked count is one before the phase (mod period) so the first running
  // edge lands exactly on the phase. The shadow phase is always < period.
  assign stop_c = (fs_q == '0) ? (ps_q - ONE) : (fs_q - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q    <= CNT_W'(DEF_PERIOD);
      h_q    <= CNT_W'(DEF_HIGH);
      ps_q   <= CNT_W'(DEF_PERIOD);
      hs_q   <= CNT_W'(DEF_HIGH);
      fs_q   <= '0;
      c_q    <= CNT_W'(DEF_PERIOD - 1);
      out_q  <= 1'b0;
      strb_q <= 1'b0;
    end else begin
      // Shadow load; any transfer on this same edge still sees the old
      // shadow because of non-blocking semantics.
      if (wr) begin
        ps_q <= wr_period;
        hs_q <= wr_high;
        fs_q <= wr_phase;
      end

      if (!run) begin
        p_q    <= ps_q;
        h_q    <= hs_q;
        c_q    <= stop_c;
        out_q  <= 1'b0;
        strb_q <= 1'b0;
      end else if (sync) begin
        p_q    <= ps_q;
        h_q    <= hs_q;
        c_q    <= fs_q;
        out_q  <= (fs_q < hs_q);
        strb_q <= (fs_q == '0);
      end else if (wrap) begin
        // Period boundary: adopt the shadow, evaluate count 0 with new H.
        p_q    <= ps_q;
        h_q    <= hs_q;
        c_q    <= '0;
        out_q  <= (hs_q != '0);
        strb_q <= 1'b1;
      end else begin
        c_q    <= c_inc;
        out_q  <= (c_inc < h_q);
        strb_q <= 1'b0;
      end
    end
  end

  assign eigen_out    = out_q;
  assign frame_strobe = strb_q;

endmodule

// File: rtl/eigen_freq_gen.sv
// Multi-channel eigen-frequency pattern generator for the FOCT modulation
// front end. Produces NCH independent periodic on/off patterns, each with
// a double-buffered period, high time and phase.
// Ports: Refin_Clk (reference clock), SYS_START (async active-low reset),
// Run (level enable), Sync (realign pulse), cfg (configuration bus, slave),
// Eigen_Out (pattern bits), Frame_Strobe (count-0 pulses).
module eigen_freq_gen
  import eigen_freq_pkg::*;
#(
  parameter int NCH        = 2,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEF_PERIOD = LEGACY_PERIOD,
  parameter int DEF_HIGH0  = LEGACY_HIGH_TEMP,
  parameter int DEF_HIGH1  = LEGACY_HIGH_CUR
) (
  input  logic                Refin_Clk,
  input  logic                SYS_START,
  input  logic                Run,
  input  logic                Sync,
  eigen_freq_gen_if.slave     cfg,
  output logic [NCH-1:0]      Eigen_Out,
  output logic [NCH-1:0]      Frame_Strobe
);

  logic wr_ok;
  logic cfg_err_q;

  assign wr_ok = (32'(cfg.Cfg_Ch) < 32'(NCH)) &&
                 is_valid_cfg(32'(cfg.Cfg_Period), 32'(cfg.Cfg_Phase));

  always_ff @(posedge Refin_Clk or negedge SYS_START) begin
    if (!SYS_START) cfg_err_q <= 1'b0;
    else            cfg_err_q <= cfg.Cfg_We && !wr_ok;
  end

  assign cfg.Cfg_Err = cfg_err_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = cfg.Cfg_We && wr_ok && (32'(cfg.Cfg_Ch) == 32'(i));

    eigen_freq_chan #(
      .CNT_W      (CNT_W),
      .DEF_PERIOD (DEF_PERIOD),
      .DEF_HIGH   ((i == 0) ? DEF_HIGH0 : DEF_HIGH1)
    ) u_chan (
      .clk          (Refin_Clk),
      .rst_n        (SYS_START),
      .run          (Run),
      .sync         (Sync),
      .wr           (wr_sel),
      .wr_period    (cfg.Cfg_Period),
      .wr_high      (cfg.Cfg_High),
      .wr_phase     (cfg.Cfg_Phase),
      .eigen_out    (Eigen_Out[i]),
      .frame_strobe (Frame_Strobe[i])
    );
  end

endmodule

// File: tb/tb_eigen_freq_gen.sv
// Directed bench for eigen_freq_gen with three channels (so that an
// out-of-range channel number is representable on Cfg_Ch).
module tb_eigen_freq_gen;
  import eigen_freq_pkg::*;

  localparam int NCH   = 3;
  localparam int CNT_W = 8;

  // ---------------- clock / reset ----------------
  logic refin_clk = 1'b0;
  logic sys_start;
  logic run;
  logic sync;
  logic [NCH-1:0] eigen_out;
  logic [NCH-1:0] frame_strobe;

  always #5 refin_clk = ~refin_clk;

  eigen_freq_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) cfg_if ();

  eigen_freq_gen #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .Refin_Clk    (refin_clk),
    .SYS_START    (sys_start),
    .Run          (run),
    .Sync         (sync),
    .cfg          (cfg_if),
    .Eigen_Out    (eigen_out),
    .Frame_Strobe (frame_strobe)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge refin_clk);
    #1;
  endtask

  task automatic set_cfg(input logic [1:0] ch, input cfg_t c);
    cfg_if.Cfg_We     = 1'b1;
    cfg_if.Cfg_Ch     = ch;
    cfg_if.Cfg_Period = c.period;
    cfg_if.Cfg_High   = c.high;
    cfg_if.Cfg_Phase  = c.phase;
  endtask

  task automatic idle_cfg();
    cfg_if.Cfg_We     = 1'b0;
    cfg_if.Cfg_Ch     = '0;
    cfg_if.Cfg_Period = '0;
    cfg_if.Cfg_High   = '0;
    cfg_if.Cfg_Phase  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [11:0] pat0, pat1, pats;
    logic [9:0]  pat5;
    logic        b0, b1, bs;
    int          k;

    sys_start = 1'b0;
    run       = 1'b0;
    sync      = 1'b0;
    idle_cfg();

    // Reset state
    #12;
    chk("reset_eigen", 32'(eigen_out), 32'h0);
    chk("reset_strobe", 32'(frame_strobe), 32'h0);
    chk("reset_err", 32'(cfg_if.Cfg_Err), 32'h0);

    @(negedge refin_clk);
    sys_start = 1'b1;
    step();
    chk("idle_eigen", 32'(eigen_out), 32'h0);

    // Defaults: ch0 100..., ch1/ch2 110..., strobes 100...
    pat0 = 12'b100100100100;
    pat1 = 12'b110110110110;
    pats = 12'b100100100100;
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      b0 = pat0[11-i];
      b1 = pat1[11-i];
      bs = pats[11-i];
      chk($sformatf("dflt_eigen_%0d", i), 32'(eigen_out), 32'({b1, b1, b0}));
      chk($sformatf("dflt_strobe_%0d", i), 32'(frame_strobe), 32'({bs, bs, bs}));
    end

    // Reconfigure ch0 mid-period (write while count is 1)
    step();
    chk("recfg_c0", 32'(eigen_out[0]), 32'h1);
    step();
    chk("recfg_c1", 32'(eigen_out[0]), 32'h0);
    set_cfg(2'd0, '{period: 8'd5, high: 8'd2, phase: 8'd0});
    step();
    idle_cfg();
    chk("recfg_c2_old", 32'(eigen_out[0]), 32'h0);
    chk("recfg_no_err", 32'(cfg_if.Cfg_Err), 32'h0);
    pat5 = 10'b1100011000;
    for (int i = 0; i < 10; i++) begin
      step();
      b0 = pat5[9-i];
      chk($sformatf("recfg_pat_%0d", i), 32'(eigen_out[0]), 32'(b0));
      chk($sformatf("recfg_strobe_%0d", i), 32'(frame_strobe[0]), 32'((i % 5) == 0));
    end

    // Rejected writes: ch0 pattern (P=5,H=2) must carry on untouched
    k = 0;
    for (int w = 0; w < 3; w++) begin
      case (w)
        0:       set_cfg(2'd0, '{period: 8'd1, high: 8'd1, phase: 8'd0});
        1:       set_cfg(2'd0, '{period: 8'd4, high: 8'd1, phase: 8'd4});
        default: set_cfg(2'd3, '{period: 8'd4, high: 8'd4, phase: 8'd0});
      endcase
      step();
      idle_cfg();
      chk($sformatf("rej_err_%0d", w), 32'(cfg_if.Cfg_Err), 32'h1);
      chk($sformatf("rej_pat_a_%0d", w), 32'(eigen_out[0]), 32'((k % 5) < 2));
      k++;
      step();
      chk($sformatf("rej_err_clr_%0d", w), 32'(cfg_if.Cfg_Err), 32'h0);
      chk($sformatf("rej_pat_b_%0d", w), 32'(eigen_out[0]), 32'((k % 5) < 2));
      k++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rej_keep_%0d", i), 32'(eigen_out[0]), 32'((k % 5) < 2));
      k++;
    end

    // Sync: ch1 P=4,H=1,F=2; ch0 (P5,H2,F0) and ch2 (defaults) realign to 0
    set_cfg(2'd1, '{period: 8'd4, high: 8'd1, phase: 8'd2});
    step();
    idle_cfg();
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_e0", 32'(eigen_out), 32'b101);
    chk("sync_s0", 32'(frame_strobe), 32'b101);
    step();
    chk("sync_e1", 32'(eigen_out), 32'b101);
    chk("sync_s1", 32'(frame_strobe), 32'b000);
    step();
    chk("sync_e2", 32'(eigen_out), 32'b010);
    chk("sync_s2", 32'(frame_strobe), 32'b010);

    // Edge cases: ch0 H=0 (constant low), ch1 H=9 with P=4 (constant high)
    set_cfg(2'd0, '{period: 8'd4, high: 8'd0, phase: 8'd0});
    step();
    set_cfg(2'd1, '{period: 8'd4, high: 8'd9, phase: 8'd0});
    step();
    idle_cfg();
    sync = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      sync = 1'b0;
      chk($sformatf("edge_eigen_%0d", i), 32'(eigen_out[1:0]), 32'b10);
      chk($sformatf("edge_strobe_%0d", i), 32'(frame_strobe[1:0]),
          ((i % 4) == 0) ? 32'b11 : 32'b00);
    end

    // Run drop for 3 cycles, with a ch1 write (P4,H1,F2) while stopped
    run = 1'b0;
    step();
    chk("stop_e0", 32'({eigen_out, frame_strobe}), 32'h0);
    set_cfg(2'd1, '{period: 8'd4, high: 8'd1, phase: 8'd2});
    step();
    idle_cfg();
    chk("stop_e1", 32'({eigen_out, frame_strobe}), 32'h0);
    step();
    chk("stop_e2", 32'({eigen_out, frame_strobe}), 32'h0);
    run = 1'b1;
    step();
    chk("restart_e0", 32'(eigen_out), 32'b100);
    chk("restart_s0", 32'(frame_strobe), 32'b101);
    step();
    chk("restart_e1", 32'(eigen_out), 32'b100);
    chk("restart_s1", 32'(frame_strobe), 32'b000);
    step();
    chk("restart_e2", 32'(eigen_out), 32'b010);
    chk("restart_s2", 32'(frame_strobe), 32'b010);
    set_cfg(2'd0, '{period: 8'd1, high: 8'd0, phase: 8'd0});
    step();
    idle_cfg();
    chk("pre_rst_e", 32'(eigen_out), 32'b100);
    chk("pre_rst_s", 32'(frame_strobe), 32'b100);
    chk("pre_rst_err", 32'(cfg_if.Cfg_Err), 32'h1);

    // Asynchronous reset mid-pattern, then defaults must come back
    #2;
    sys_start = 1'b0;
    #1;
    chk("arst_eigen", 32'(eigen_out), 32'h0);
    chk("arst_strobe", 32'(frame_strobe), 32'h0);
    chk("arst_err", 32'(cfg_if.Cfg_Err), 32'h0);
    @(negedge refin_clk);
    sys_start = 1'b1;
    step();
    chk("post_rst_e0", 32'(eigen_out), 32'b111);
    chk("post_rst_s0", 32'(frame_strobe), 32'b111);
    step();
    chk("post_rst_e1", 32'(eigen_out), 32'b110);
    chk("post_rst_s1", 32'(frame_strobe), 32'b000);
    step();
    chk("post_rst_e2", 32'(eigen_out), 32'b000);
    chk("post_rst_s2", 32'(frame_strobe), 32'b000);
    step();
    chk("post_rst_e3", 32'(eigen_out), 32'b111);
    chk("post_rst_s3", 32'(frame_strobe), 32'b111);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
